// File: rtl/issue_unit_pkg.sv
// Shared types for the decode-queue consumer: unit/imm/uop enums, queue entry
// and issue packet layouts, plus immediate expansion.
package issue_unit_pkg;

    localparam int REG_W   = 5;
    localparam int NUM_EXU = 4;

    typedef enum logic [1:0] {
        EXU_ALU = 2'd0,
        EXU_MUL = 2'd1,
        EXU_JMP = 2'd2,
        EXU_MEM = 2'd3
    } exe_unit_type_t;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_B = 2'd1,
        IMM_U = 2'd2,
        IMM_J = 2'd3
    } imm_type_t;

    typedef enum logic [4:0] {
        UOP_ADD  = 5'd0,
        UOP_ADDI = 5'd1,
        UOP_MUL  = 5'd2,
        UOP_LW   = 5'd3,
        UOP_SW   = 5'd4,
        UOP_BEQ  = 5'd5,
        UOP_JAL  = 5'd6,
        UOP_LUI  = 5'd7
    } uop_t;

    // 50-bit queue head entry
    typedef struct packed {
        logic           legal;
        uop_t           uopcode;
        exe_unit_type_t exu_type;
        logic           has_rd;
        logic           has_rs1;
        logic           has_rs2;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        imm_type_t      imm_type;
        logic [19:0]    packed_imm;
        logic           taken;
        logic           shadowed;
    } queue_item_t;

    typedef struct packed {
        uop_t           uopcode;
        exe_unit_type_t exu_type;
        logic           has_rd;
        logic           has_rs1;
        logic           has_rs2;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [31:0]    imm;
        logic           taken;
        logic           shadowed;
    } issue_pkt_t;

    function automatic logic [31:0] expand_imm(input imm_type_t t, input logic [19:0] p);
        logic [31:0] v;
        case (t)
            IMM_I:   v = {{20{p[11]}}, p[11:0]};
            IMM_B:   v = {{19{p[11]}}, p[11:0], 1'b0};
            IMM_U:   v = {p, 12'h000};
            IMM_J:   v = {{11{p[19]}}, p, 1'b0};
            default: v = 32'h0000_0000;
        endcase
        return v;
    endfunction

    function automatic issue_pkt_t make_pkt(input queue_item_t q);
        issue_pkt_t k;
        k.uopcode  = q.uopcode;
        k.exu_type = q.exu_type;
        k.has_rd   = q.has_rd;
        k.has_rs1  = q.has_rs1;
        k.has_rs2  = q.has_rs2;
        k.rd       = q.rd;
        k.rs1      = q.rs1;
        k.rs2      = q.rs2;
        k.imm      = expand_imm(q.imm_type, q.packed_imm);
        k.taken    = q.taken;
        k.shadowed = q.shadowed;
        return k;
    endfunction

endpackage

// File: rtl/issue_unit_scoreboard.sv
// Register busy bits: set on dispatch, cleared by writeback, set wins on a tie.
// busy_eff exposes the same-cycle writeback clears to the hazard check.
module issue_unit_scoreboard
    import issue_unit_pkg::*;
#(
    parameter int WB_PORTS = 2,
    parameter int NREGS    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_en,
    input  logic [REG_W-1:0]          set_rd,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [REG_W*WB_PORTS-1:0] wb_rd,
    output logic [NREGS-1:0]          busy,
    output logic [NREGS-1:0]          busy_eff
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] clr_s;
    logic [NREGS-1:0] set_s;
    logic [NREGS-1:0] busy_nxt_s;

    // Clear/set masks; duplicate writebacks just OR into the same bit, x0 is forced free.
    always_comb begin
        clr_s = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            clr_s = clr_s | (NREGS'(wb_valid[k]) << wb_rd[k*REG_W +: REG_W]);
        end
        set_s      = NREGS'(set_en) << set_rd;
        busy_eff   = busy_r & ~clr_s;
        busy_nxt_s = (busy_eff | set_s) & ~NREGS'(1'b1);
    end

    // Busy-bit state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/issue_unit.sv
// Pops the instruction queue head when hazard-free and the single output
// register can accept it, then presents it to the selected execution unit.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int WB_PORTS = 2,
    parameter int NREGS    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  queue_item_t               q_item,
    input  logic                      q_empty,
    output logic                      q_pop,
    input  logic                      flush,
    input  logic [NUM_EXU-1:0]        exu_ready,
    output logic [NUM_EXU-1:0]        iss_valid,
    output issue_pkt_t                iss_pkt,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [REG_W*WB_PORTS-1:0] wb_rd,
    output logic [NREGS-1:0]          sb_busy
);

    logic [NUM_EXU-1:0] iss_valid_r;
    issue_pkt_t         iss_pkt_r;
    logic               held_valid_s;
    logic               fire_s;
    logic               issuable_s;
    logic               q_pop_s;
    logic               set_en_s;
    logic [NREGS-1:0]   busy_eff_s;
    logic [NREGS-1:0]   pend_s;
    logic [NREGS-1:0]   hazard_s;

    issue_unit_scoreboard #(
        .WB_PORTS(WB_PORTS),
        .NREGS   (NREGS)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en_s),
        .set_rd  (iss_pkt_r.rd),
        .wb_valid(wb_valid),
        .wb_rd   (wb_rd),
        .busy    (sb_busy),
        .busy_eff(busy_eff_s)
    );

    // Held packet's rd counts as busy until it dispatches (RAW and WAW both stall on it).
    always_comb begin
        held_valid_s = |iss_valid_r;
        fire_s       = |(iss_valid_r & exu_ready);
        pend_s       = '0;
        if (held_valid_s && iss_pkt_r.has_rd) begin
            pend_s[iss_pkt_r.rd] = 1'b1;
        end else begin
            pend_s = '0;
        end
        hazard_s   = (busy_eff_s | pend_s) & ~NREGS'(1'b1);
        issuable_s = !q_empty && q_item.legal
                     && !(q_item.has_rs1 && hazard_s[q_item.rs1])
                     && !(q_item.has_rs2 && hazard_s[q_item.rs2])
                     && !(q_item.has_rd  && hazard_s[q_item.rd]);
        q_pop_s    = issuable_s && (!held_valid_s || fire_s) && !flush && !rst;
        set_en_s   = fire_s && iss_pkt_r.has_rd && (iss_pkt_r.rd != 5'd0);
    end

    // Output register: load on pop, drop on fire or flush, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_r <= '0;
            iss_pkt_r   <= '0;
        end else if (q_pop_s) begin
            iss_valid_r <= 4'b0001 << q_item.exu_type;
            iss_pkt_r   <= make_pkt(q_item);
        end else if (flush || fire_s) begin
            iss_valid_r <= '0;
            iss_pkt_r   <= iss_pkt_r;
        end else begin
            iss_valid_r <= iss_valid_r;
            iss_pkt_r   <= iss_pkt_r;
        end
    end

    assign q_pop     = q_pop_s;
    assign iss_valid = iss_valid_r;
    assign iss_pkt   = iss_pkt_r;

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: directed scenarios followed by random
// traffic, all checked against an in-order queue-and-busy-set reference.
module tb_issue_unit;
    import issue_unit_pkg::*;

    logic        clk;
    logic        rst;
    queue_item_t q_item;
    logic        q_empty;
    logic        q_pop;
    logic        flush;
    logic [3:0]  exu_ready;
    logic [3:0]  iss_valid;
    issue_pkt_t  iss_pkt;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic [31:0] sb_busy;

    issue_unit #(.WB_PORTS(2), .NREGS(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_item   (q_item),
        .q_empty  (q_empty),
        .q_pop    (q_pop),
        .flush    (flush),
        .exu_ready(exu_ready),
        .iss_valid(iss_valid),
        .iss_pkt  (iss_pkt),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .sb_busy  (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    queue_item_t prog[$];
    int          head = 0;
    issue_pkt_t  exp_q[$];
    logic [31:0] mbusy = '0;
    logic        rand_mode = 1'b0;
    logic        drv_rst = 1'b1;
    logic [3:0]  drv_ready = 4'hF;
    logic        drv_flush = 1'b0;
    logic [1:0]  drv_wbv = 2'b00;
    logic [9:0]  drv_wbr = 10'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic queue_item_t mk(input uop_t u, input exe_unit_type_t e,
                                       input logic hrd, input logic [4:0] rd,
                                       input logic hr1, input logic [4:0] rs1,
                                       input logic hr2, input logic [4:0] rs2,
                                       input imm_type_t it, input logic [19:0] pi);
        queue_item_t q;
        q = '0;
        q.legal = 1'b1; q.uopcode = u; q.exu_type = e;
        q.has_rd = hrd; q.rd = rd; q.has_rs1 = hr1; q.rs1 = rs1;
        q.has_rs2 = hr2; q.rs2 = rs2; q.imm_type = it; q.packed_imm = pi;
        return q;
    endfunction

    // Reference packet: immediate computed arithmetically from the encoding rules
    function automatic issue_pkt_t model_pkt(input queue_item_t q);
        issue_pkt_t  k;
        int          s;
        logic [11:0] lo;
        logic [19:0] hi;
        lo = q.packed_imm[11:0];
        hi = q.packed_imm;
        case (q.imm_type)
            IMM_I:   s = $signed(lo);
            IMM_B:   s = $signed(lo) * 2;
            IMM_U:   s = int'(hi) * 4096;
            default: s = $signed(hi) * 2;
        endcase
        k.uopcode = q.uopcode; k.exu_type = q.exu_type;
        k.has_rd = q.has_rd; k.has_rs1 = q.has_rs1; k.has_rs2 = q.has_rs2;
        k.rd = q.rd; k.rs1 = q.rs1; k.rs2 = q.rs2;
        k.imm = s; k.taken = q.taken; k.shadowed = q.shadowed;
        return k;
    endfunction

    function automatic logic [4:0] pick_reg();
        int cand[$];
        for (int r = 1; r < 32; r++) if (mbusy[r]) cand.push_back(r);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            return 5'(cand[$urandom_range(0, cand.size() - 1)]);
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic cycle();
        @(negedge clk);
        rst = drv_rst;
        if (rand_mode) begin
            for (int i = 0; i < 4; i++) exu_ready[i] = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < 2; k++) begin
                wb_valid[k]      = ($urandom_range(0, 2) == 0);
                wb_rd[k*5 +: 5]  = pick_reg();
            end
        end else begin
            exu_ready = drv_ready; flush = drv_flush;
            wb_valid = drv_wbv; wb_rd = drv_wbr;
        end
        q_empty = (head >= prog.size());
        if (q_empty) q_item = '0;
        else q_item = prog[head];
        #3;
    endtask

    // Monitor: compares DUT against the in-order reference every cycle.
    always begin
        logic [31:0] clr, eff, hz, nb;
        logic        held, fire, exp_pop;
        logic [3:0]  ev;
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            mbusy = '0;
        end else begin
            clr = '0;
            for (int k = 0; k < 2; k++)
                if (wb_valid[k] && wb_rd[k*5 +: 5] != 5'd0) clr[wb_rd[k*5 +: 5]] = 1'b1;
            eff  = mbusy & ~clr;
            held = (exp_q.size() != 0);
            hz   = eff;
            fire = 1'b0;
            ev   = 4'd0;
            if (held) begin
                if (exp_q[0].has_rd && exp_q[0].rd != 5'd0) hz[exp_q[0].rd] = 1'b1;
                fire = exu_ready[exp_q[0].exu_type];
                ev   = 4'b0001 << exp_q[0].exu_type;
            end
            chk("iss_valid", 64'(iss_valid), 64'(ev));
            if (held) chk("iss_pkt", 64'(iss_pkt), 64'(exp_q[0]));
            chk("sb_busy", 64'(sb_busy), 64'(mbusy));
            exp_pop = !q_empty && q_item.legal && !flush && (!held || fire)
                      && !(q_item.has_rs1 && q_item.rs1 != 5'd0 && hz[q_item.rs1])
                      && !(q_item.has_rs2 && q_item.rs2 != 5'd0 && hz[q_item.rs2])
                      && !(q_item.has_rd  && q_item.rd  != 5'd0 && hz[q_item.rd]);
            chk("q_pop", 64'(q_pop), 64'(exp_pop));
            nb = eff;
            if (fire && exp_q[0].has_rd && exp_q[0].rd != 5'd0) nb[exp_q[0].rd] = 1'b1;
            if (fire || (held && flush)) void'(exp_q.pop_front());
            if (q_pop) begin
                exp_q.push_back(model_pkt(q_item));
                head++;
            end
            mbusy = nb;
        end
    end

    task automatic wait_uop(input uop_t u);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (iss_valid != 4'd0 && iss_pkt.uopcode == u) return;
        end
        n_vec++; n_err++;
        $display("FAIL wait_uop%0d: no issue seen, required within 20 cycles", u);
    endtask

    task automatic wait_pop_rd(input logic [4:0] r);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (q_pop && q_item.has_rd && q_item.rd == r) return;
        end
        n_vec++; n_err++;
        $display("FAIL wait_pop_rd%0d: no pop seen, required within 20 cycles", r);
    endtask

    logic [31:0] imm_exp[3];
    uop_t        imm_uop[3];

    initial begin
        queue_item_t lw;
        queue_item_t it;
        int          cyc;
        rst = 1'b1; q_item = '0; q_empty = 1'b1; flush = 1'b0;
        exu_ready = 4'd0; wb_valid = 2'd0; wb_rd = 10'd0;
        imm_exp = '{32'h1234_5000, 32'hFFF0_0000, 32'hFFFF_F000};
        imm_uop = '{UOP_LUI, UOP_JAL, UOP_BEQ};

        // 1/2: ADDI x5,x1,-4 then dependent ADD x6,x5,x2
        prog.push_back(mk(UOP_ADDI, EXU_ALU, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0, IMM_I, 20'h00FFC));
        prog.push_back(mk(UOP_ADD,  EXU_ALU, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd2, IMM_I, 20'h00000));
        cycle(); cycle();
        chk("rst_q_pop", 64'(q_pop), 64'd0);
        drv_rst = 1'b0;
        cycle();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_pkt", 64'(iss_pkt), 64'd0);
        chk("rst_sb_busy", 64'(sb_busy), 64'd0);
        chk("addi_pop", 64'(q_pop), 64'd1);
        cycle();
        chk("addi_valid", 64'(iss_valid), 64'd1);
        chk("addi_imm", 64'(iss_pkt.imm), 64'hFFFF_FFFC);
        chk("raw_pend", 64'(q_pop), 64'd0);
        cycle();
        chk("busy5", 64'(sb_busy[5]), 64'd1);
        chk("raw_busy", 64'(q_pop), 64'd0);
        cycle();
        chk("raw_busy2", 64'(q_pop), 64'd0);
        drv_wbv = 2'b01; drv_wbr = 10'd5;
        cycle();
        chk("wb_bypass_pop", 64'(q_pop), 64'd1);
        drv_wbv = 2'b00;
        cycle();
        chk("add_valid", 64'(iss_valid), 64'd1);
        chk("add_rs1", 64'(iss_pkt.rs1), 64'd5);

        // 3: LW held while the mem unit is not ready
        lw = mk(UOP_LW, EXU_MEM, 1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 5'd0, IMM_I, 20'h00010);
        prog.push_back(lw);
        prog.push_back(mk(UOP_ADDI, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_I, 20'h00000));
        drv_ready = 4'b0111;
        cycle();
        chk("lw_pop", 64'(q_pop), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("lw_hold_valid", 64'(iss_valid), 64'h8);
            chk("lw_hold_pkt", 64'(iss_pkt), 64'(model_pkt(lw)));
            chk("lw_hold_nopop", 64'(q_pop), 64'd0);
        end
        drv_ready = 4'hF;
        cycle();
        chk("lw_fire_pop", 64'(q_pop), 64'd1);
        cycle();
        chk("nop_valid", 64'(iss_valid), 64'd1);
        chk("busy8", 64'(sb_busy[8]), 64'd1);

        // 4: flush of a held MUL x7
        prog.push_back(mk(UOP_MUL, EXU_MUL, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, IMM_I, 20'h00000));
        prog.push_back(mk(UOP_ADDI, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_I, 20'h00000));
        drv_ready = 4'b1101;
        cycle();
        chk("mul_pop", 64'(q_pop), 64'd1);
        cycle();
        chk("mul_valid", 64'(iss_valid), 64'h2);
        drv_flush = 1'b1;
        cycle();
        chk("flush_nopop", 64'(q_pop), 64'd0);
        drv_flush = 1'b0; drv_ready = 4'hF;
        cycle();
        chk("flush_valid", 64'(iss_valid), 64'd0);
        chk("flush_busy7", 64'(sb_busy[7]), 64'd0);

        // 5: immediate formats
        prog.push_back(mk(UOP_LUI, EXU_ALU, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_U, 20'h12345));
        prog.push_back(mk(UOP_JAL, EXU_JMP, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_J, 20'h80000));
        prog.push_back(mk(UOP_BEQ, EXU_JMP, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_B, 20'h00800));
        for (int i = 0; i < 3; i++) begin
            wait_uop(imm_uop[i]);
            chk("imm_fmt", 64'(iss_pkt.imm), 64'(imm_exp[i]));
        end

        // 6: set beats same-cycle writeback; x0 never becomes busy
        prog.push_back(mk(UOP_ADD, EXU_ALU, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, IMM_I, 20'h00000));
        prog.push_back(mk(UOP_ADD, EXU_ALU, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, IMM_I, 20'h00000));
        wait_pop_rd(5'd9);
        drv_wbv = 2'b11; drv_wbr = {5'd9, 5'd9};
        cycle();
        chk("rd9_fire", 64'(iss_valid), 64'd1);
        drv_wbv = 2'b00; drv_wbr = 10'd0;
        cycle();
        chk("set_wins_busy9", 64'(sb_busy[9]), 64'd1);
        cycle();
        chk("x0_never_busy", 64'(sb_busy[0]), 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            it = '0;
            it.legal      = 1'b1;
            it.uopcode    = uop_t'(5'($urandom_range(0, 7)));
            it.exu_type   = exe_unit_type_t'(2'($urandom_range(0, 3)));
            it.has_rd     = 1'($urandom_range(0, 1));
            it.has_rs1    = 1'($urandom_range(0, 1));
            it.has_rs2    = 1'($urandom_range(0, 1));
            it.rd         = 5'($urandom_range(0, 7));
            it.rs1        = 5'($urandom_range(0, 7));
            it.rs2        = 5'($urandom_range(0, 7));
            it.imm_type   = imm_type_t'(2'($urandom_range(0, 3)));
            it.packed_imm = 20'($urandom);
            it.taken      = 1'($urandom_range(0, 1));
            it.shadowed   = 1'($urandom_range(0, 1));
            prog.push_back(it);
        end
        rand_mode = 1'b1;
        cyc = 0;
        while ((head < prog.size() || exp_q.size() != 0) && cyc < 20000) begin
            cycle();
            cyc++;
        end
        rand_mode = 1'b0;
        drv_ready = 4'hF; drv_flush = 1'b0; drv_wbv = 2'b00;
        if (cyc >= 20000) begin
            n_vec++; n_err++;
            $display("FAIL random_drain: %0d items left, required 0", prog.size() - head);
        end
        cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
